// File: rtl/fdiv_pkg.sv
// Shared types and constants for the Goldschmidt divider back end
// (normalise / round / result handshake).
package fdiv_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ARM    = 3'd1,
        WAIT   = 3'd2,
        SETTLE = 3'd3,
        NORM   = 3'd4,
        RND    = 3'd5,
        OUT    = 3'd6
    } fdiv_state_e;

    localparam logic [2:0] RM_RNE = 3'd0;
    localparam logic [2:0] RM_RTZ = 3'd1;
    localparam logic [2:0] RM_RDN = 3'd2;
    localparam logic [2:0] RM_RUP = 3'd3;
    localparam logic [2:0] RM_RMM = 3'd4;

    localparam int FLG_TMO = 3;
    localparam int FLG_OVF = 2;
    localparam int FLG_UNF = 1;
    localparam int FLG_INX = 0;

    localparam int RES_MAXW = 64;

    // Quiet NaN: all-ones exponent plus the fraction MSB, positive sign.
    function automatic logic [RES_MAXW-1:0] qnan_word(input int expw, input int fmsb);
        logic [RES_MAXW-1:0] w;
        for (int i = 0; i < RES_MAXW; i++) begin
            if ((i >= fmsb) && (i <= fmsb + expw)) begin
                w[i] = 1'b1;
            end else begin
                w[i] = 1'b0;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/fdiv_rounder.sv
// Combinational mantissa rounder: truncated mantissa plus guard/sticky and a
// rounding mode in, rounded mantissa, carry-out and inexact out.
module fdiv_rounder
    import fdiv_pkg::*;
#(
    parameter int MW = 24
) (
    input  logic [MW-1:0] mant,
    input  logic          guard,
    input  logic          sticky,
    input  logic          sign,
    input  logic [2:0]    rm,
    output logic [MW-1:0] mant_rnd,
    output logic          carry,
    output logic          inexact
);

    logic          round_up_s;
    logic          lost_s;
    logic [MW:0]   sum_s;

    // Increment decision for each rounding direction.
    always_comb begin
        round_up_s = 1'b0;
        lost_s     = guard | sticky;
        case (rm)
            RM_RNE:  round_up_s = guard & (sticky | mant[0]);
            RM_RTZ:  round_up_s = 1'b0;
            RM_RDN:  round_up_s = lost_s & sign;
            RM_RUP:  round_up_s = lost_s & ~sign;
            RM_RMM:  round_up_s = guard;
            default: round_up_s = guard & (sticky | mant[0]);
        endcase
    end

    // Apply the increment; the extra bit is the mantissa carry-out.
    always_comb begin
        sum_s    = {1'b0, mant} + {{MW{1'b0}}, round_up_s};
        mant_rnd = sum_s[MW-1:0];
        carry    = sum_s[MW];
        inexact  = lost_s;
    end

endmodule

// File: rtl/fdiv_norm_round.sv
// Divider back end: tracks a launched divide, normalises and rounds the quotient.
// Optional FDIV_ROUND_MODES_EN adds an rm[2:0] port (RNE/RTZ/RDN/RUP/RMM).
module fdiv_norm_round
    import fdiv_pkg::*;
#(
    parameter int WID    = 32,
    parameter int QPOINT = 32,
    parameter int FMSB   = 22,
    parameter int EXPW   = 8,
    parameter int BIAS   = 127,
    parameter int TMO    = 255
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   sgn,
    input  logic [EXPW-1:0]        ea,
    input  logic [EXPW-1:0]        eb,
    input  logic                   div_done,
    input  logic [2*WID-1:0]       q,
    input  logic [7:0]             lzcnt,
`ifdef FDIV_ROUND_MODES_EN
    input  logic [2:0]             rm,
`endif
    output logic                   o_valid,
    input  logic                   o_ready,
    output logic [EXPW+FMSB+1:0]   o_res,
    output logic [3:0]             o_flags,
    output logic                   busy
);

    localparam int QW = 2 * WID;
    localparam int MW = FMSB + 2;
    localparam int RW = EXPW + FMSB + 2;
    localparam int EW = EXPW + 3;
    localparam int TW = $clog2(TMO + 1);

    localparam logic signed [EW-1:0] BIAS_E = EW'(BIAS);
    localparam logic signed [EW-1:0] OFF_E  = EW'(QW - 1 - QPOINT);
    localparam logic signed [EW-1:0] EMAX_E = EW'((1 << EXPW) - 1);
    localparam logic signed [EW-1:0] ZERO_E = EW'(0);
    localparam logic [TW-1:0]        TMO_LAST = TW'(TMO - 1);
    localparam logic [RW-1:0]        QNAN_RES = RW'(qnan_word(EXPW, FMSB));

    fdiv_state_e             state_r;
    fdiv_state_e             state_nx_s;
    logic [TW-1:0]           timer_r;
    logic                    timer_hit_s;
    logic                    tmo_exit_s;

    logic                    sgn_r;
    logic [EXPW-1:0]         ea_r;
    logic [EXPW-1:0]         eb_r;
    logic [QW-1:0]           q_r;
    logic [7:0]              lz_r;
    logic [QW-1:0]           m_r;
    logic signed [EW-1:0]    e_r;
    logic                    zero_r;

    logic [QW-1:0]           norm_m_s;
    logic signed [EW-1:0]    norm_e_s;
    logic [2:0]              rm_eff_s;
    logic                    ovf_to_max_s;

    logic [MW-1:0]           mant_s;
    logic                    guard_s;
    logic                    sticky_s;
    logic [MW-1:0]           mant_rnd_s;
    logic                    carry_s;
    logic                    inexact_s;
    logic [MW-1:0]           mant_fin_s;
    logic signed [EW-1:0]    e_fin_s;
    logic [RW-1:0]           res_rnd_s;
    logic [3:0]              flags_rnd_s;

    logic                    o_valid_r;
    logic [RW-1:0]           o_res_r;
    logic [3:0]              o_flags_r;
    logic                    busy_r;

`ifdef FDIV_ROUND_MODES_EN
    logic [2:0]              rm_r;

    // Latch the rounding mode with the operands.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rm_r <= RM_RNE;
        end else if ((state_r == IDLE) && start) begin
            rm_r <= rm;
        end else begin
            rm_r <= rm_r;
        end
    end

    // Directed modes that round toward zero saturate to the largest finite value.
    always_comb begin
        rm_eff_s     = rm_r;
        ovf_to_max_s = (rm_r == RM_RTZ) ||
                       ((rm_r == RM_RDN) && !sgn_r) ||
                       ((rm_r == RM_RUP) && sgn_r);
    end
`else
    // Fixed round-to-nearest-even build.
    always_comb begin
        rm_eff_s     = RM_RNE;
        ovf_to_max_s = 1'b0;
    end
`endif

    assign timer_hit_s = (timer_r == TMO_LAST);
    assign tmo_exit_s  = ((state_r == ARM) || (state_r == WAIT)) && (state_nx_s == OUT);

    // Next-state logic; ARM waits for the divider to drop a stale done first.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nx_s = ARM;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            ARM: begin
                if (timer_hit_s) begin
                    state_nx_s = OUT;
                end else if (!div_done) begin
                    state_nx_s = WAIT;
                end else begin
                    state_nx_s = ARM;
                end
            end
            WAIT: begin
                if (div_done) begin
                    state_nx_s = SETTLE;
                end else if (timer_hit_s) begin
                    state_nx_s = OUT;
                end else begin
                    state_nx_s = WAIT;
                end
            end
            SETTLE:  state_nx_s = NORM;
            NORM:    state_nx_s = RND;
            RND:     state_nx_s = OUT;
            OUT: begin
                if (o_ready) begin
                    state_nx_s = IDLE;
                end else begin
                    state_nx_s = OUT;
                end
            end
            default: state_nx_s = IDLE;
        endcase
    end

    // State register with registered handshake and busy outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= IDLE;
            o_valid_r <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            state_r   <= state_nx_s;
            o_valid_r <= (state_nx_s == OUT);
            busy_r    <= (state_nx_s != IDLE);
        end
    end

    // Normalise so the leading one lands on the quotient MSB.
    always_comb begin
        norm_m_s = q_r << lz_r;
        norm_e_s = $signed({3'b000, ea_r}) - $signed({3'b000, eb_r}) + BIAS_E + OFF_E
                 - $signed({{(EW-8){1'b0}}, lz_r});
    end

    assign mant_s   = m_r[QW-1 -: MW];
    assign guard_s  = m_r[QW-1-MW];
    assign sticky_s = |m_r[QW-2-MW:0];

    fdiv_rounder #(
        .MW (MW)
    ) u_rounder (
        .mant     (mant_s),
        .guard    (guard_s),
        .sticky   (sticky_s),
        .sign     (sgn_r),
        .rm       (rm_eff_s),
        .mant_rnd (mant_rnd_s),
        .carry    (carry_s),
        .inexact  (inexact_s)
    );

    // Mantissa carry-out renormalises by one place and bumps the exponent.
    always_comb begin
        if (carry_s) begin
            mant_fin_s = {1'b1, mant_rnd_s[MW-1:1]};
        end else begin
            mant_fin_s = mant_rnd_s;
        end
        e_fin_s = e_r + $signed({{(EW-1){1'b0}}, carry_s});
    end

    // Final packing: exact zero, overflow, flush-to-zero or normal result.
    always_comb begin
        res_rnd_s   = {sgn_r, e_fin_s[EXPW-1:0], mant_fin_s[FMSB:0]};
        flags_rnd_s = 4'b0000;
        if (zero_r) begin
            res_rnd_s = {sgn_r, {(RW-1){1'b0}}};
        end else if (e_fin_s >= EMAX_E) begin
            if (ovf_to_max_s) begin
                res_rnd_s = {sgn_r, {(EXPW-1){1'b1}}, 1'b0, {(FMSB+1){1'b1}}};
            end else begin
                res_rnd_s = {sgn_r, {EXPW{1'b1}}, {(FMSB+1){1'b0}}};
            end
            flags_rnd_s[FLG_OVF] = 1'b1;
            flags_rnd_s[FLG_INX] = 1'b1;
        end else if (e_fin_s <= ZERO_E) begin
            res_rnd_s            = {sgn_r, {(RW-1){1'b0}}};
            flags_rnd_s[FLG_UNF] = 1'b1;
            flags_rnd_s[FLG_INX] = 1'b1;
        end else begin
            flags_rnd_s[FLG_INX] = inexact_s;
        end
    end

    // Operand capture, timer and per-stage datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            timer_r   <= {TW{1'b0}};
            sgn_r     <= 1'b0;
            ea_r      <= {EXPW{1'b0}};
            eb_r      <= {EXPW{1'b0}};
            q_r       <= {QW{1'b0}};
            lz_r      <= 8'd0;
            m_r       <= {QW{1'b0}};
            e_r       <= {EW{1'b0}};
            zero_r    <= 1'b0;
            o_res_r   <= {RW{1'b0}};
            o_flags_r <= 4'b0000;
        end else begin
            case (state_r)
                IDLE: begin
                    timer_r <= {TW{1'b0}};
                    if (start) begin
                        sgn_r <= sgn;
                        ea_r  <= ea;
                        eb_r  <= eb;
                    end
                end
                ARM, WAIT: begin
                    timer_r <= timer_r + 1'b1;
                    if (tmo_exit_s) begin
                        o_res_r   <= QNAN_RES;
                        o_flags_r <= 4'b1000;
                    end
                end
                SETTLE: begin
                    q_r  <= q;
                    lz_r <= lzcnt;
                end
                NORM: begin
                    m_r    <= norm_m_s;
                    e_r    <= norm_e_s;
                    zero_r <= (q_r == {QW{1'b0}});
                end
                RND: begin
                    o_res_r   <= res_rnd_s;
                    o_flags_r <= flags_rnd_s;
                end
                OUT:     timer_r <= timer_r;
                default: timer_r <= {TW{1'b0}};
            endcase
        end
    end

    assign o_valid = o_valid_r;
    assign o_res   = o_res_r;
    assign o_flags = o_flags_r;
    assign busy    = busy_r;

endmodule

// File: tb/tb_fdiv_norm_round.sv
// Directed-vector bench for fdiv_norm_round (default build, RNE only).
module tb_fdiv_norm_round;

    typedef struct packed {
        logic [7:0]  a;
        logic [7:0]  b;
        logic        s;
        logic [63:0] qv;
        logic [7:0]  lz;
        logic [31:0] res;
        logic [3:0]  flg;
    } vec_t;

    // e = ea-eb+127+31-lz ; mantissa = top 24 bits of q<<lz, RNE.
    localparam vec_t BASIC_V [7] = '{
        '{8'd129, 8'd128, 1'b0, 64'h0000_0001_0000_0000, 8'd31, 32'h4000_0000, 4'b0000},
        '{8'd128, 8'd128, 1'b0, 64'h0000_0002_0000_0000, 8'd30, 32'h4000_0000, 4'b0000},
        '{8'd127, 8'd127, 1'b0, 64'h0000_0000_5555_5555, 8'd33, 32'h3EAA_AAAB, 4'b0001},
        '{8'd127, 8'd127, 1'b1, 64'h0000_0000_5555_5555, 8'd33, 32'hBEAA_AAAB, 4'b0001},
        '{8'd127, 8'd127, 1'b0, 64'h0000_0001_0000_0100, 8'd31, 32'h3F80_0000, 4'b0001},
        '{8'd127, 8'd127, 1'b0, 64'h0000_0001_0000_0300, 8'd31, 32'h3F80_0002, 4'b0001},
        '{8'd127, 8'd127, 1'b0, 64'h0000_0001_FFFF_FF80, 8'd31, 32'h4000_0000, 4'b0001}
    };

    localparam vec_t SPECIAL_V [7] = '{
        '{8'd254, 8'd1,   1'b0, 64'h0000_0001_0000_0000, 8'd31, 32'h7F80_0000, 4'b0101},
        '{8'd200, 8'd72,  1'b0, 64'h0000_0001_0000_0000, 8'd31, 32'h7F80_0000, 4'b0101},
        '{8'd199, 8'd72,  1'b0, 64'h0000_0001_0000_0000, 8'd31, 32'h7F00_0000, 4'b0000},
        '{8'd1,   8'd127, 1'b0, 64'h0000_0001_0000_0000, 8'd31, 32'h0080_0000, 4'b0000},
        '{8'd0,   8'd127, 1'b0, 64'h0000_0001_0000_0000, 8'd31, 32'h0000_0000, 4'b0011},
        '{8'd1,   8'd200, 1'b1, 64'h0000_0001_0000_0000, 8'd31, 32'h8000_0000, 4'b0011},
        '{8'd127, 8'd127, 1'b1, 64'h0000_0000_0000_0000, 8'd64, 32'h8000_0000, 4'b0000}
    };

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        sgn;
    logic [7:0]  ea;
    logic [7:0]  eb;
    logic        div_done;
    logic [63:0] q;
    logic [7:0]  lzcnt;
`ifdef FDIV_ROUND_MODES_EN
    logic [2:0]  rm = 3'd0;
`endif
    logic        o_valid;
    logic        o_ready;
    logic [31:0] o_res;
    logic [3:0]  o_flags;
    logic        busy;

    int checks = 0;
    int errors = 0;

    fdiv_norm_round dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .sgn      (sgn),
        .ea       (ea),
        .eb       (eb),
        .div_done (div_done),
        .q        (q),
        .lzcnt    (lzcnt),
`ifdef FDIV_ROUND_MODES_EN
        .rm       (rm),
`endif
        .o_valid  (o_valid),
        .o_ready  (o_ready),
        .o_res    (o_res),
        .o_flags  (o_flags),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Launch one divide from IDLE; optionally accept the result afterwards.
    task automatic launch(input vec_t v, input logic accept,
                          output logic got, output logic [31:0] res, output logic [3:0] flg);
        start = 1'b1; sgn = v.s; ea = v.a; eb = v.b; div_done = 1'b0;
        @(posedge clk); #1;
        start = 1'b0; sgn = ~v.s; ea = 8'h00; eb = 8'hFF;
        repeat (4) begin @(posedge clk); #1; end
        q = v.qv; lzcnt = v.lz; div_done = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (!got) begin
                @(posedge clk); #1;
                got = o_valid;
            end
        end
        res = o_res;
        flg = o_flags;
        if (accept) begin
            o_ready = 1'b1;
            @(posedge clk); #1;
            o_ready = 1'b0;
            div_done = 1'b0;
        end
    endtask

    task automatic test_reset;
        rst = 1'b0; start = 1'b0; sgn = 1'b0; ea = 8'h00; eb = 8'h00;
        div_done = 1'b0; q = 64'h0; lzcnt = 8'h00; o_ready = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset o_valid got %b want 0", o_valid); end
        checks++; if (o_res !== 32'h0) begin errors++; $display("FAIL reset o_res got %h want 0", o_res); end
        checks++; if (o_flags !== 4'h0) begin errors++; $display("FAIL reset o_flags got %b want 0000", o_flags); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset busy got %b want 0", busy); end
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic run_table(input string name, input vec_t v, input int idx);
        logic got; logic [31:0] res; logic [3:0] flg;
        launch(v, 1'b1, got, res, flg);
        checks++; if (got !== 1'b1) begin errors++; $display("FAIL %s[%0d] o_valid timeout got %b want 1", name, idx, got); end
        checks++; if (res !== v.res) begin errors++; $display("FAIL %s[%0d] o_res got %h want %h", name, idx, res, v.res); end
        checks++; if (flg !== v.flg) begin errors++; $display("FAIL %s[%0d] o_flags got %b want %b", name, idx, flg, v.flg); end
    endtask

    task automatic test_rounding;
        for (int i = 0; i < 7; i++) run_table("basic", BASIC_V[i], i);
    endtask

    task automatic test_specials;
        for (int i = 0; i < 7; i++) run_table("special", SPECIAL_V[i], i);
    endtask

    task automatic test_timeout;
        int cnt;
        start = 1'b1; sgn = 1'b0; ea = 8'd127; eb = 8'd127; div_done = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        cnt = 0;
        while (!o_valid && cnt < 400) begin
            @(posedge clk); #1;
            cnt++;
        end
        checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL timeout o_valid got %b want 1", o_valid); end
        checks++; if (cnt != 255) begin errors++; $display("FAIL timeout cycles got %0d want 255", cnt); end
        checks++; if (o_res !== 32'h7FC0_0000) begin errors++; $display("FAIL timeout o_res got %h want 7fc00000", o_res); end
        checks++; if (o_flags !== 4'b1000) begin errors++; $display("FAIL timeout o_flags got %b want 1000", o_flags); end
        o_ready = 1'b1;
        @(posedge clk); #1;
        o_ready = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL timeout busy after accept got %b want 0", busy); end
    endtask

    task automatic test_backpressure;
        logic got; logic [31:0] res; logic [3:0] flg;
        launch(BASIC_V[2], 1'b0, got, res, flg);
        checks++; if (got !== 1'b1) begin errors++; $display("FAIL hold o_valid timeout got %b want 1", got); end
        for (int i = 0; i < 5; i++) begin
            start = (i == 1) ? 1'b1 : 1'b0;
            ea = 8'd200; eb = 8'd10;
            checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL hold[%0d] o_valid got %b want 1", i, o_valid); end
            checks++; if (o_res !== 32'h3EAA_AAAB) begin errors++; $display("FAIL hold[%0d] o_res got %h want 3eaaaaab", i, o_res); end
            checks++; if (o_flags !== 4'b0001) begin errors++; $display("FAIL hold[%0d] o_flags got %b want 0001", i, o_flags); end
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL hold[%0d] busy got %b want 1", i, busy); end
            @(posedge clk); #1;
        end
        start = 1'b0;
        o_ready = 1'b1;
        @(posedge clk); #1;
        o_ready = 1'b0; div_done = 1'b0;
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL hold retire o_valid got %b want 0", o_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL hold retire busy got %b want 0", busy); end
    endtask

    task automatic test_back_to_back;
        logic got; logic [31:0] res; logic [3:0] flg;
        o_ready = 1'b1;
        launch(BASIC_V[0], 1'b0, got, res, flg);
        checks++; if (got !== 1'b1) begin errors++; $display("FAIL b2b first valid got %b want 1", got); end
        checks++; if (res !== 32'h4000_0000) begin errors++; $display("FAIL b2b first o_res got %h want 40000000", res); end
        @(posedge clk); #1;
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL b2b retire o_valid got %b want 0", o_valid); end
        o_ready = 1'b0;
        launch(BASIC_V[3], 1'b1, got, res, flg);
        checks++; if (got !== 1'b1) begin errors++; $display("FAIL b2b second valid got %b want 1", got); end
        checks++; if (res !== 32'hBEAA_AAAB) begin errors++; $display("FAIL b2b second o_res got %h want beaaaaab", res); end
        checks++; if (flg !== 4'b0001) begin errors++; $display("FAIL b2b second o_flags got %b want 0001", flg); end
    endtask

    task automatic test_reset_mid;
        logic got; logic [31:0] res; logic [3:0] flg;
        start = 1'b1; sgn = 1'b0; ea = 8'd127; eb = 8'd127; div_done = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b0;
        @(posedge clk); #1;
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL midrst o_valid got %b want 0", o_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst busy got %b want 0", busy); end
        q = 64'h0000_0000_5555_5555; lzcnt = 8'd33; div_done = 1'b1;
        rst = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst discard busy got %b want 0", busy); end
        div_done = 1'b0;
        launch(BASIC_V[0], 1'b1, got, res, flg);
        checks++; if (got !== 1'b1) begin errors++; $display("FAIL midrst next valid got %b want 1", got); end
        checks++; if (res !== 32'h4000_0000) begin errors++; $display("FAIL midrst next o_res got %h want 40000000", res); end
        checks++; if (flg !== 4'b0000) begin errors++; $display("FAIL midrst next o_flags got %b want 0000", flg); end
    endtask

    initial begin
        test_reset();
        test_rounding();
        test_specials();
        test_timeout();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
